// File: rtl/delay_pkg.sv
// Shared types and constants for the delay-line sequencer.
// Holds the sequencer state encoding, the delay clamp floor and the RAM read latency.
package delay_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam int MIN_DELAY = 1;
  localparam int RAM_LAT   = 1;

endpackage

// File: rtl/delay_ptr_wrap.sv
// Combinational modular pointer arithmetic over a SIZE-deep ring: (ptr - delay) mod SIZE and ptr+1 mod SIZE.
// Zero latency; no handshake. Inputs must already be < SIZE (delay in 1..SIZE-1).
module delay_ptr_wrap #(
  parameter int ADDR_WIDTH = 14,
  parameter int SIZE       = 12000
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [ADDR_WIDTH-1:0] delay,
  output logic [ADDR_WIDTH-1:0] sub_addr,
  output logic [ADDR_WIDTH-1:0] inc_addr
);

  localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

  logic [ADDR_WIDTH:0] ptr_w;
  logic [ADDR_WIDTH:0] dly_w;
  logic [ADDR_WIDTH:0] diff;

  assign ptr_w = {1'b0, ptr};
  assign dly_w = {1'b0, delay};

  // One extra bit keeps ptr+SIZE from overflowing before the subtract.
  always_comb begin
    diff = '0;
    if (ptr_w >= dly_w) diff = ptr_w - dly_w;
    else                diff = ptr_w + SIZE_W - dly_w;
    sub_addr = ADDR_WIDTH'(diff);
    inc_addr = (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/delay_seq_ctrl.sv
// Delay-line sequencer: per audio_ready, read at wr_ptr-delay, wait one cycle, write at wr_ptr (mix_valid/mem_we at +3).
// Strobes arriving while busy are dropped and latch overrun. Optional zero-fill build: DELAY_FLUSH_EN.
import delay_pkg::*;

module delay_seq_ctrl #(
  parameter int ADDR_WIDTH    = 14,
  parameter int SIZE          = 12000,
  parameter int DEFAULT_DELAY = 11936
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  audio_ready,
  input  logic                  en,
  input  logic                  cfg_load,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_we,
  output logic                  mem_wzero,
  output logic                  mix_valid,
  output logic                  mix_sel,
  output logic                  busy,
  output logic                  overrun,
  output logic [ADDR_WIDTH-1:0] delay_cur
);

  localparam logic [ADDR_WIDTH-1:0] MAX_D = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] MIN_D = ADDR_WIDTH'(MIN_DELAY);
  localparam logic [ADDR_WIDTH-1:0] DEF_D = ADDR_WIDTH'(DEFAULT_DELAY);
`ifdef DELAY_FLUSH_EN
  localparam state_t RST_STATE = FLUSH;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [ADDR_WIDTH-1:0]   delay_clamped;
  logic [ADDR_WIDTH-1:0]   delay_eff;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   wr_ptr_inc;
  logic                    accept;
`ifdef DELAY_FLUSH_EN
  logic [ADDR_WIDTH-1:0]   flush_cnt;
`endif

  always_comb begin
    delay_clamped = cfg_delay;
    if (cfg_delay < MIN_D)      delay_clamped = MIN_D;
    else if (cfg_delay > MAX_D) delay_clamped = MAX_D;
  end

  // A load coinciding with the strobe takes effect for that very sample.
  assign delay_eff = cfg_load ? delay_clamped : delay_cur;

  delay_ptr_wrap #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE       (SIZE)
  ) u_wrap (
    .ptr      (wr_ptr),
    .delay    (delay_eff),
    .sub_addr (rd_addr),
    .inc_addr (wr_ptr_inc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef DELAY_FLUSH_EN
        if (cfg_load && (delay_clamped != delay_cur)) state_nxt = FLUSH;
        else
`endif
        if (audio_ready && en) state_nxt = READ;
      end
      READ:  state_nxt = WAIT;
      WAIT:  state_nxt = WRITE;
      WRITE: state_nxt = IDLE;
`ifdef DELAY_FLUSH_EN
      FLUSH: if (flush_cnt == MAX_D) state_nxt = IDLE;
`else
      FLUSH: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && (state_nxt == READ);

  // Write strobes are gated by reset so an interrupted sequence never lands a partial write.
  always_comb begin
    mem_we    = rst && ((state == WRITE) || (state == FLUSH));
    mem_wzero = rst && (state == FLUSH);
    mix_valid = rst && (state == WRITE);
    busy      = (state != IDLE);
`ifdef DELAY_FLUSH_EN
    mem_waddr = (state == FLUSH) ? flush_cnt : waddr_q;
`else
    mem_waddr = waddr_q;
`endif
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= RST_STATE;
      wr_ptr    <= '0;
      waddr_q   <= '0;
      mem_raddr <= '0;
      delay_cur <= DEF_D;
      mix_sel   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_load) delay_cur <= delay_clamped;
      if (audio_ready && ((state != IDLE) || (state_nxt == FLUSH))) overrun <= 1'b1;
      if (accept) begin
        mem_raddr <= rd_addr;
        mix_sel   <= 1'b1;
      end else if ((state == IDLE) && audio_ready && !en) begin
        mix_sel <= 1'b0;
      end
      if (state == WAIT)  waddr_q <= wr_ptr;
      if (state == WRITE) wr_ptr  <= wr_ptr_inc;
`ifdef DELAY_FLUSH_EN
      if ((state == FLUSH) && (flush_cnt == MAX_D)) wr_ptr <= '0;
`endif
    end
  end

`ifdef DELAY_FLUSH_EN
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      flush_cnt <= (flush_cnt == MAX_D) ? '0 : flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// Directed bench for delay_seq_ctrl: pointer/address sequence, latency, wrap, clamp, overrun, bypass, reset.
// With DELAY_FLUSH_EN defined it checks the zero-fill sweep instead.
module tb_delay_seq_ctrl;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        audio_ready = 1'b0;
  logic        en = 1'b1;
  logic        cfg_load = 1'b0;
  logic [13:0] cfg_delay = '0;
  logic [13:0] mem_raddr;
  logic [13:0] mem_waddr;
  logic        mem_we;
  logic        mem_wzero;
  logic        mix_valid;
  logic        mix_sel;
  logic        busy;
  logic        overrun;
  logic [13:0] delay_cur;

  int n_chk  = 0;
  int n_fail = 0;

  delay_seq_ctrl dut (
    .CLK         (CLK),
    .rst         (rst),
    .audio_ready (audio_ready),
    .en          (en),
    .cfg_load    (cfg_load),
    .cfg_delay   (cfg_delay),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_we      (mem_we),
    .mem_wzero   (mem_wzero),
    .mix_valid   (mix_valid),
    .mix_sel     (mix_sel),
    .busy        (busy),
    .overrun     (overrun),
    .delay_cur   (delay_cur)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load(input logic [13:0] d);
    cfg_delay = d;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  // Strobe then run to the first cycle a new strobe is accepted (N+4).
  task automatic run_sample(output logic [13:0] ra, output logic [13:0] wa, output logic we);
    audio_ready = 1'b1;
    tick();
    audio_ready = 1'b0;
    ra = mem_raddr;
    tick();
    tick();
    wa = mem_waddr;
    we = mem_we;
    tick();
  endtask

  initial begin : stim
    logic [13:0] ra;
    logic [13:0] wa;
    logic        we;
    int          cnt;
    logic [13:0] exp_ra [6];
    exp_ra = '{14'd11996, 14'd11997, 14'd11998, 14'd11999, 14'd0, 14'd1};

    tick();
`ifndef DELAY_FLUSH_EN
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mix_sel", mix_sel, 0);
    chk("rst_delay", delay_cur, 11936);
    do_reset();

    load(14'd4);
    chk("load4", delay_cur, 4);

    // Six samples 8 cycles apart, with full latency/pulse-width checks.
    for (int i = 0; i < 6; i++) begin
      audio_ready = 1'b1;
      chk("n0_busy", busy, 0);
      tick();
      audio_ready = 1'b0;
      chk("n1_busy", busy, 1);
      chk("n1_we", mem_we, 0);
      chk("n1_raddr", mem_raddr, exp_ra[i]);
      tick();
      chk("n2_busy", busy, 1);
      chk("n2_mv", mix_valid, 0);
      tick();
      chk("n3_we", mem_we, 1);
      chk("n3_mv", mix_valid, 1);
      chk("n3_sel", mix_sel, 1);
      chk("n3_waddr", mem_waddr, i);
      tick();
      chk("n4_we", mem_we, 0);
      chk("n4_mv", mix_valid, 0);
      chk("n4_busy", busy, 0);
      repeat (4) tick();
    end

    // Walk wr_ptr up to the last address.
    for (int i = 6; i < 11999; i++) run_sample(ra, wa, we);
    load(14'd1);
    run_sample(ra, wa, we);
    chk("wrap_raddr_a", ra, 11998);
    chk("wrap_waddr_a", wa, 11999);
    run_sample(ra, wa, we);
    chk("wrap_raddr_b", ra, 11999);
    chk("wrap_waddr_b", wa, 0);
    chk("wrap_we_b", we, 1);

    load(14'd0);
    chk("clamp_lo", delay_cur, 1);
    load(14'd16383);
    chk("clamp_hi", delay_cur, 11999);
    load(14'd12000);
    chk("clamp_size", delay_cur, 11999);

    // Load and strobe together: new delay applies to this sample (wr_ptr=1).
    cfg_delay = 14'd10;
    cfg_load  = 1'b1;
    run_sample(ra, wa, we);
    cfg_load  = 1'b0;
    chk("same_cyc_raddr", ra, 11991);
    chk("same_cyc_delay", delay_cur, 10);
    chk("same_cyc_waddr", wa, 1);

    // Second strobe two cycles after the first is dropped.
    audio_ready = 1'b1;
    tick();
    audio_ready = 1'b0;
    tick();
    audio_ready = 1'b1;
    tick();
    audio_ready = 1'b0;
    chk("ovr_we", mem_we, 1);
    chk("ovr_waddr", mem_waddr, 2);
    chk("ovr_set", overrun, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we) cnt++;
    end
    chk("ovr_no_extra_we", cnt, 0);
    chk("ovr_sticky", overrun, 1);

    // Bypass strobe: no RAM traffic, mixer passes x only.
    en = 1'b0;
    audio_ready = 1'b1;
    tick();
    audio_ready = 1'b0;
    chk("byp_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_we) cnt++;
      tick();
    end
    chk("byp_no_we", cnt, 0);
    chk("byp_mix_sel", mix_sel, 0);
    en = 1'b1;
    run_sample(ra, wa, we);
    chk("resume_waddr", wa, 3);
    chk("resume_raddr", ra, 11993);
    chk("ovr_still", overrun, 1);

    // Reset in the middle of a sequence.
    audio_ready = 1'b1;
    tick();
    audio_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_delay", delay_cur, 11936);
    tick();
    chk("midrst_we_hold", mem_we, 0);
    rst = 1'b1;
    tick();
`else
    chk("rst_busy", busy, 1);
    chk("rst_we", mem_we, 0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12000; i++) begin
      if (!(mem_we && mem_wzero && (mem_waddr == 14'(i)) && busy)) cnt++;
      if (i == 5) audio_ready = 1'b1;
      tick();
      audio_ready = 1'b0;
    end
    chk("flush_bad_cycles", cnt, 0);
    chk("flush_done_busy", busy, 0);
    chk("flush_done_we", mem_we, 0);
    chk("flush_ovr", overrun, 1);

    do_reset();
    repeat (100) tick();
    chk("midflush_addr", mem_waddr, 100);
    rst = 1'b0;
    #1;
    chk("midflush_rst_we", mem_we, 0);
    tick();
    rst = 1'b1;
    chk("restart_addr", mem_waddr, 0);
    chk("restart_we", mem_we, 1);
    repeat (12000) tick();
    chk("restart_done", busy, 0);

    load(14'd5);
    chk("cfg_flush_busy", busy, 1);
    chk("cfg_flush_addr", mem_waddr, 0);
    chk("cfg_flush_zero", mem_wzero, 1);
    chk("cfg_flush_delay", delay_cur, 5);
    repeat (12000) tick();
    chk("cfg_flush_done", busy, 0);
    run_sample(ra, wa, we);
    chk("post_flush_waddr", wa, 0);
    chk("post_flush_raddr", ra, 11995);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
